// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types and the two-way round-robin pick rule for the 2:1 AXI arbiter.
package axi_arb_pkg;
   localparam int MST_IDX_W = 1;
   typedef logic [MST_IDX_W-1:0] mst_idx_t;
   typedef enum logic {ARB_IDLE, ARB_SEND} arb_state_e;
   function automatic mst_idx_t rr_pick(input logic [1:0] req, input mst_idx_t prio);
      return (&req) ? prio : mst_idx_t'(req[1]);
   endfunction
endpackage

// File: rtl/axi_bus_if.sv
// AXI_BUS: AXI4 bundle with Master/Slave modports, parameterised per port (ID width differs up/downstream).
interface AXI_BUS #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_USER_WIDTH = 6
);
   logic [AXI_ID_WIDTH-1:0]     aw_id, ar_id, b_id, r_id;
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr, ar_addr;
   logic [7:0]                  aw_len, ar_len;
   logic [2:0]                  aw_size, ar_size, aw_prot, ar_prot;
   logic [1:0]                  aw_burst, ar_burst, b_resp, r_resp;
   logic                        aw_lock, ar_lock;
   logic [3:0]                  aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
   logic [AXI_USER_WIDTH-1:0]   aw_user, ar_user, w_user, b_user, r_user;
   logic [AXI_DATA_WIDTH-1:0]   w_data, r_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic aw_valid, aw_ready, ar_valid, ar_ready, w_valid, w_ready, w_last;
   logic b_valid, b_ready, r_valid, r_ready, r_last;
   modport Master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
             aw_region, aw_user, aw_valid, w_data, w_strb, w_last, w_user, w_valid, b_ready,
             ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
             ar_region, ar_user, ar_valid, r_ready,
      input  aw_ready, w_ready, b_id, b_resp, b_user, b_valid, ar_ready,
             r_id, r_data, r_resp, r_last, r_user, r_valid
   );
   modport Slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
             aw_region, aw_user, aw_valid, w_data, w_strb, w_last, w_user, w_valid, b_ready,
             ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
             ar_region, ar_user, ar_valid, r_ready,
      output aw_ready, w_ready, b_id, b_resp, b_user, b_valid, ar_ready,
             r_id, r_data, r_resp, r_last, r_user, r_valid
   );
endinterface

// File: rtl/axi_arb_rr.sv
// axi_arb_rr: two-way grant picker; round-robin pointer by default, fixed master-0 priority
// when AXI_ARB_FIXED_PRIO_EN is defined.
module axi_arb_rr
   import axi_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       gnt_en_i,
   output mst_idx_t   gnt_o
);
`ifdef AXI_ARB_FIXED_PRIO_EN
   logic unused_in;
   assign unused_in = ^{clk_i, rst_ni, gnt_en_i};
   assign gnt_o = rr_pick(req_i, '0);
`else
   mst_idx_t prio_q;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) prio_q <= '0;
      else if (gnt_en_i) prio_q <= ~gnt_o;
   end
   assign gnt_o = rr_pick(req_i, prio_q);
`endif
endmodule

// File: rtl/axi_2to1_arbiter.sv
// axi_2to1_arbiter: shares one AXI4 slave port between two masters; ID widened by the master index.
// Define AXI_ARB_FIXED_PRIO_EN for fixed master-0 priority instead of round-robin.
module axi_2to1_arbiter
   import axi_arb_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_USER_WIDTH = 6,
   parameter int W_FIFO_DEPTH   = 4
)(
   input  logic   ACLK,
   input  logic   ARESETn,
   AXI_BUS.Slave  s0,
   AXI_BUS.Slave  s1,
   AXI_BUS.Master m
);
   localparam int FW = AXI_ADDR_WIDTH + AXI_USER_WIDTH + 29;
   localparam int PW = $clog2(W_FIFO_DEPTH);
   localparam int CW = PW + 1;
   arb_state_e            ar_st_q, aw_st_q;
   logic [FW-1:0]         ar_q, aw_q, ar_f0, ar_f1, aw_f0, aw_f1;
   logic [AXI_ID_WIDTH:0] ar_id_q, aw_id_q;
   mst_idx_t              ar_gnt, aw_gnt, w_head;
   mst_idx_t              fifo_q [W_FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         cnt_q;
   logic                  ar_take, aw_take, w_full, w_empty, w_pop, r_sel, b_sel;
   assign ar_f0 = {s0.ar_addr, s0.ar_len, s0.ar_size, s0.ar_burst, s0.ar_lock, s0.ar_cache,
                   s0.ar_prot, s0.ar_qos, s0.ar_region, s0.ar_user};
   assign ar_f1 = {s1.ar_addr, s1.ar_len, s1.ar_size, s1.ar_burst, s1.ar_lock, s1.ar_cache,
                   s1.ar_prot, s1.ar_qos, s1.ar_region, s1.ar_user};
   assign aw_f0 = {s0.aw_addr, s0.aw_len, s0.aw_size, s0.aw_burst, s0.aw_lock, s0.aw_cache,
                   s0.aw_prot, s0.aw_qos, s0.aw_region, s0.aw_user};
   assign aw_f1 = {s1.aw_addr, s1.aw_len, s1.aw_size, s1.aw_burst, s1.aw_lock, s1.aw_cache,
                   s1.aw_prot, s1.aw_qos, s1.aw_region, s1.aw_user};
   assign ar_take = ARESETn && ar_st_q == ARB_IDLE && (s0.ar_valid || s1.ar_valid);
   assign aw_take = ARESETn && aw_st_q == ARB_IDLE && !w_full && (s0.aw_valid || s1.aw_valid);
   axi_arb_rr u_ar_rr (.clk_i(ACLK), .rst_ni(ARESETn), .req_i({s1.ar_valid, s0.ar_valid}),
                       .gnt_en_i(ar_take), .gnt_o(ar_gnt));
   axi_arb_rr u_aw_rr (.clk_i(ACLK), .rst_ni(ARESETn), .req_i({s1.aw_valid, s0.aw_valid}),
                       .gnt_en_i(aw_take), .gnt_o(aw_gnt));
   assign s0.ar_ready = ar_take && ar_gnt == 1'b0;
   assign s1.ar_ready = ar_take && ar_gnt == 1'b1;
   assign s0.aw_ready = aw_take && aw_gnt == 1'b0;
   assign s1.aw_ready = aw_take && aw_gnt == 1'b1;
   always_ff @(posedge ACLK) begin
      if (!ARESETn) ar_st_q <= ARB_IDLE;
      else if (ar_take) begin
         ar_st_q <= ARB_SEND;
         ar_q    <= ar_gnt ? ar_f1 : ar_f0;
         ar_id_q <= {ar_gnt, ar_gnt ? s1.ar_id : s0.ar_id};
      end else if (ar_st_q == ARB_SEND && m.ar_ready) ar_st_q <= ARB_IDLE;
   end
   always_ff @(posedge ACLK) begin
      if (!ARESETn) aw_st_q <= ARB_IDLE;
      else if (aw_take) begin
         aw_st_q <= ARB_SEND;
         aw_q    <= aw_gnt ? aw_f1 : aw_f0;
         aw_id_q <= {aw_gnt, aw_gnt ? s1.aw_id : s0.aw_id};
      end else if (aw_st_q == ARB_SEND && m.aw_ready) aw_st_q <= ARB_IDLE;
   end
   assign m.ar_valid = ar_st_q == ARB_SEND;
   assign m.ar_id    = ar_id_q;
   assign {m.ar_addr, m.ar_len, m.ar_size, m.ar_burst, m.ar_lock, m.ar_cache,
           m.ar_prot, m.ar_qos, m.ar_region, m.ar_user} = ar_q;
   assign m.aw_valid = aw_st_q == ARB_SEND;
   assign m.aw_id    = aw_id_q;
   assign {m.aw_addr, m.aw_len, m.aw_size, m.aw_burst, m.aw_lock, m.aw_cache,
           m.aw_prot, m.aw_qos, m.aw_region, m.aw_user} = aw_q;
   // W-order FIFO: full is judged on the registered count, so a same-cycle pop never frees a slot early
   assign w_full  = cnt_q == CW'(W_FIFO_DEPTH);
   assign w_empty = cnt_q == '0;
   assign w_head  = fifo_q[rd_ptr_q];
   assign w_pop   = m.w_valid && m.w_ready && m.w_last;
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (aw_take) begin
            fifo_q[wr_ptr_q] <= aw_gnt;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + CW'(aw_take) - CW'(w_pop);
      end
   end
   assign m.w_valid  = !w_empty && (w_head ? s1.w_valid : s0.w_valid);
   assign m.w_data   = w_head ? s1.w_data : s0.w_data;
   assign m.w_strb   = w_head ? s1.w_strb : s0.w_strb;
   assign m.w_last   = w_head ? s1.w_last : s0.w_last;
   assign m.w_user   = w_head ? s1.w_user : s0.w_user;
   assign s0.w_ready = !w_empty && w_head == 1'b0 && m.w_ready;
   assign s1.w_ready = !w_empty && w_head == 1'b1 && m.w_ready;
   assign r_sel = m.r_id[AXI_ID_WIDTH];
   assign b_sel = m.b_id[AXI_ID_WIDTH];
   assign s0.r_valid = m.r_valid && !r_sel;
   assign s1.r_valid = m.r_valid && r_sel;
   assign m.r_ready  = r_sel ? s1.r_ready : s0.r_ready;
   assign s0.r_id    = m.r_id[AXI_ID_WIDTH-1:0];
   assign s1.r_id    = m.r_id[AXI_ID_WIDTH-1:0];
   assign {s0.r_data, s0.r_resp, s0.r_last, s0.r_user} = {m.r_data, m.r_resp, m.r_last, m.r_user};
   assign {s1.r_data, s1.r_resp, s1.r_last, s1.r_user} = {m.r_data, m.r_resp, m.r_last, m.r_user};
   assign s0.b_valid = m.b_valid && !b_sel;
   assign s1.b_valid = m.b_valid && b_sel;
   assign m.b_ready  = b_sel ? s1.b_ready : s0.b_ready;
   assign s0.b_id    = m.b_id[AXI_ID_WIDTH-1:0];
   assign s1.b_id    = m.b_id[AXI_ID_WIDTH-1:0];
   assign {s0.b_resp, s0.b_user} = {m.b_resp, m.b_user};
   assign {s1.b_resp, s1.b_user} = {m.b_resp, m.b_user};
endmodule
